// File: rtl/arm_imm_encoder.sv
// Sequential ARM data-processing immediate encoder: finds (imm8, rot4) with value = imm8 ROR 2*rot4.
// Define ARM_IMM_FAST_EN to test two rotations per cycle; results are identical, only latency changes.
module arm_imm_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int ROT_WIDTH  = 4,
    parameter int IMM_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic                  carry_flag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IMM_WIDTH-1:0]  imm8,
    output logic [ROT_WIDTH-1:0]  rot4,
    output logic                  encodable,
    output logic                  shift_carry_out
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [DATA_WIDTH-1:0]   val_q;
    logic                    carry_q;
    logic [ROT_WIDTH-1:0]    cnt;

    logic                    hit;
    logic                    last;
    logic [IMM_WIDTH-1:0]    hit_imm;
    logic [ROT_WIDTH-1:0]    hit_rot;
    logic [ROT_WIDTH-1:0]    cnt_step;

    // Rotate left by amt: upper half of the doubled word shifted left.
    function automatic logic [DATA_WIDTH-1:0] rotl(
        input logic [DATA_WIDTH-1:0] v,
        input logic [ROT_WIDTH:0]    amt
    );
        logic [2*DATA_WIDTH-1:0] dbl;
        dbl = {v, v} << amt;
        return dbl[2*DATA_WIDTH-1:DATA_WIDTH];
    endfunction

`ifdef ARM_IMM_FAST_EN
    logic [ROT_WIDTH-1:0]  cnt_hi;
    logic [DATA_WIDTH-1:0] cand_lo;
    logic [DATA_WIDTH-1:0] cand_hi;
    logic                  hit_lo;
    logic                  hit_hi;

    // Lower rotation of the pair is checked first so the canonical encoding wins.
    always_comb begin
        cnt_hi   = cnt + ROT_WIDTH'(1);
        cand_lo  = rotl(val_q, {cnt, 1'b0});
        cand_hi  = rotl(val_q, {cnt_hi, 1'b0});
        hit_lo   = (cand_lo[DATA_WIDTH-1:IMM_WIDTH] == '0);
        hit_hi   = (cand_hi[DATA_WIDTH-1:IMM_WIDTH] == '0);
        hit      = hit_lo | hit_hi;
        hit_rot  = hit_lo ? cnt : cnt_hi;
        hit_imm  = hit_lo ? cand_lo[IMM_WIDTH-1:0] : cand_hi[IMM_WIDTH-1:0];
        last     = (cnt == ROT_WIDTH'((2 ** ROT_WIDTH) - 2));
        cnt_step = ROT_WIDTH'(2);
    end
`else
    logic [DATA_WIDTH-1:0] cand;

    always_comb begin
        cand     = rotl(val_q, {cnt, 1'b0});
        hit      = (cand[DATA_WIDTH-1:IMM_WIDTH] == '0);
        hit_rot  = cnt;
        hit_imm  = cand[IMM_WIDTH-1:0];
        last     = (cnt == '1);
        cnt_step = ROT_WIDTH'(1);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = SEARCH;
            SEARCH:  if (hit || last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q           <= '0;
            carry_q         <= 1'b0;
            cnt             <= '0;
            imm8            <= '0;
            rot4            <= '0;
            encodable       <= 1'b0;
            shift_carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        val_q   <= value;
                        carry_q <= carry_flag;
                        cnt     <= '0;
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        imm8            <= hit_imm;
                        rot4            <= hit_rot;
                        encodable       <= 1'b1;
                        // A non-zero rotate makes the shifter carry equal to the result MSB.
                        shift_carry_out <= (hit_rot == '0) ? carry_q : val_q[DATA_WIDTH-1];
                    end else if (last) begin
                        imm8            <= '0;
                        rot4            <= '0;
                        encodable       <= 1'b0;
                        shift_carry_out <= carry_q;
                    end else begin
                        cnt <= cnt + cnt_step;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/arm_imm_encoder.md
Name: arm_imm_encoder

Overview:
- Sequential encoder that converts a 32-bit constant into the ARM data-processing immediate form: an 8-bit imm8 and a 4-bit rot4, where value = imm8 rotated right by 2*rot4.
- This is the inverse of the barrel shifter's rotate-immediate path.
- Sits in front of the operand-2 path and instruction assembly logic.
- Searches one rotation per cycle under a valid/ready handshake.
- Reports whether the value is encodable and the carry-out the shifter will produce for that encoding.

Parameters:
- DATA_WIDTH, 32, operand width (fixed at 32 for ARM; other values unsupported)
- ROT_WIDTH, 4, rotate-field width (DATA_WIDTH/2 candidate rotations)
- IMM_WIDTH, 8, immediate-field width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  value/carry_flag are valid
- in_ready  output  1  encoder can accept a new value
- value  input  32  constant to encode
- carry_flag  input  1  current CPSR C flag
- out_valid  output  1  result registers valid
- out_ready  input  1  consumer accepts the result
- imm8  output  8  encoded immediate
- rot4  output  4  encoded rotate (effective rotate = 2*rot4)
- encodable  output  1  1 = a valid (imm8, rot4) pair exists
- shift_carry_out  output  1  shifter carry for this encoding

Behaviour:
- Reset: one clock and one asynchronous active-high reset (rst), which takes effect immediately.
  - On rst: state=IDLE, in_ready=1, out_valid=0, imm8=0, rot4=0, encodable=0, shift_carry_out=0, counter=0.
- States:
  - IDLE: in_ready=1. On in_valid at an edge, latch value and carry_flag, set cnt=0, go to SEARCH.
  - SEARCH: in_ready=0, out_valid=0. Each cycle compute cand = value rotated LEFT by 2*cnt (mod 32).
    - If cand[31:8]==0: register imm8=cand[7:0], rot4=cnt, encodable=1. Go to DONE.
    - Else if cnt==15: register imm8=0, rot4=0, encodable=0. Go to DONE.
    - Else cnt=cnt+1.
  - DONE: out_valid=1, in_ready=0. All outputs held stable while out_ready=0. On out_ready at an edge, go to IDLE with out_valid=0; output registers keep their last values.
- Rotation choice: the smallest matching rot4 always wins (canonical encoding).
- Carry rule:
  - encodable and rot4==0: shift_carry_out = latched carry_flag.
  - encodable and rot4!=0: shift_carry_out = value[31].
  - Not encodable: shift_carry_out = latched carry_flag.
- Latency: with acceptance at edge E0, out_valid goes high after edge E(rot4+1). Not encodable: after E16. Worst-case throughput is one value per 17 cycles plus one handshake cycle.
- in_valid while not in IDLE is ignored. The source must hold value until in_ready.
- value==0 encodes as imm8=0, rot4=0, encodable=1 after E1.
- Wrap-around: rotation is modulo 32, so bit patterns straddling bit31/bit0 must be found.
- Reset mid-SEARCH or mid-DONE aborts the operation, with no output pulse.

Optional Feature:
- Macro ARM_IMM_FAST_EN.
- Defined: SEARCH evaluates two candidates per cycle, 2*cnt and 2*(cnt+1). cnt steps by 2; the lower matching rotation wins; the terminal check is cnt==14.
  - out_valid after edge E(floor(rot4/2)+1).
  - Not encodable: after E8.
- Undefined: one candidate per cycle, as above.
- Results (imm8, rot4, encodable, carry) are identical in both builds; only latency differs.

Test Plan:
- value=0x000000FF, carry_flag=1 -> imm8=0xFF, rot4=0, encodable=1, shift_carry_out=1; out_valid after E1.
- value=0xFF000000, carry_flag=0 -> imm8=0xFF, rot4=4, encodable=1, shift_carry_out=1; out_valid after E5 (E3 with ARM_IMM_FAST_EN).
- value=0xF000000F (wrap) -> imm8=0xFF, rot4=2, encodable=1, shift_carry_out=1.
- value=0x00000102, carry_flag=1 -> encodable=0, imm8=0, rot4=0, shift_carry_out=1; out_valid after E16 (E8 fast).
- Backpressure: value=0x3FC (imm8=0xFF, rot4=15), out_ready held 0 for 4 cycles.
  - Required: outputs stable, in_ready=0, and a second in_valid with 0x1 ignored.
  - After out_ready: IDLE, then 0x1 accepted -> imm8=0x01, rot4=0.
- Assert rst during SEARCH for value 0x00000102 -> immediately out_valid=0, in_ready=1, all outputs 0. A following value=0x80 gives imm8=0x80, rot4=0.
